// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (a - b), LSB first, one bit per clock.
// A single borrow flop carries the borrow between cycles; start/done handshake around it.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         sbit,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         ovf,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sa_q, sb_q, sr_q, sr_d;
  logic           bf_q, bf_d;
  logic [CW-1:0]  cnt_q;
  logic           a_msb_q, b_msb_q;
  logic [N-1:0]   diff_q;
  logic           borrow_q, ovf_q;
  logic           d_bit;
  logic           last_bit;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign d_bit    = sa_q[0] ^ sb_q[0] ^ bf_q;
  assign bf_d     = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bf_q);
  assign sr_d     = {d_bit, sr_q[N-1:1]};
  assign last_bit = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    sbit = 1'b0;
    case (state_q)
      RUN: begin
        busy = 1'b1;
        sbit = d_bit;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      bf_q     <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            sr_q    <= '0;
            bf_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= a[N-1];
            b_msb_q <= b[N-1];
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sr_q  <= sr_d;
          bf_q  <= bf_d;
          cnt_q <= cnt_q + CW'(1);
          // Results publish only on the last bit so they hold steady between operations.
          if (last_bit) begin
            diff_q   <= sr_d;
            borrow_q <= bf_d;
            ovf_q    <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (N=8): hand-computed vectors, handshake
// spacing, mid-operation reset and reset/start priority.
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic         sbit;
  logic [N-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] last_diff;

  serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sbit      (sbit),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation; sbit sequence must equal the difference bits LSB first.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [N-1:0] ed, input logic eb, input logic eo);
    a = av;
    b = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      a = N'($urandom_range(0, 255));
      b = N'($urandom_range(0, 255));
      chk($sformatf("sbit[%0d] %0d-%0d", i, av, bv), 32'(sbit), 32'(ed[i]));
      chk("busy_in_run", 32'(busy), 32'd1);
      chk("done_in_run", 32'(done), 32'd0);
      chk("diff_hold_in_run", 32'(diff), 32'(last_diff));
      step();
    end
    chk($sformatf("done %0d-%0d", av, bv), 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("sbit_in_done", 32'(sbit), 32'd0);
    chk($sformatf("diff %0d-%0d", av, bv), 32'(diff), 32'(ed));
    chk($sformatf("borrow %0d-%0d", av, bv), 32'(borrow), 32'(eb));
    chk($sformatf("ovf %0d-%0d", av, bv), 32'(ovf), 32'(eo));
    last_diff = ed;
    step();
    chk("done_width", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("diff_stable_idle", 32'(diff), 32'(ed));
  endtask

  initial begin
    int  pulses;
    int  last_pulse;
    logic prev_done;
    int  waited;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    last_diff = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sbit", 32'(sbit), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    step();

    run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
    run_op(8'd5, 8'd9, 8'hFC, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run_op(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);

    // start held high: operands are only meaningful while idle.
    pulses = 0;
    last_pulse = -1;
    prev_done = 1'b0;
    start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!busy) begin
        a = 8'd3;
        b = 8'd1;
      end else begin
        a = N'($urandom_range(0, 255));
        b = N'($urandom_range(0, 255));
      end
      if (done) begin
        chk("hs_done_width", 32'(prev_done), 32'd0);
        chk("hs_diff", 32'(diff), 32'd2);
        if (last_pulse >= 0) chk("hs_period", 32'(cyc - last_pulse), 32'd10);
        last_pulse = cyc;
        pulses++;
      end
      prev_done = done;
      step();
    end
    chk("hs_pulse_count", 32'(pulses), 32'd4);
    start = 1'b0;
    waited = 0;
    while (busy && waited < 20) begin
      step();
      waited++;
    end
    chk("hs_return_idle", 32'(busy), 32'd0);
    last_diff = 8'd2;

    // Reset while bit 4 is on sbit aborts the operation.
    a = 8'd200;
    b = 8'd50;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      step();
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    last_diff = '0;
    run_op(8'd200, 8'd50, 8'd150, 1'b0, 1'b0);

    // Reset wins over start at the same edge.
    rst = 1'b1;
    start = 1'b1;
    a = 8'd9;
    b = 8'd4;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_prio_busy", 32'(busy), 32'd0);
    chk("rst_prio_diff", 32'(diff), 32'd0);
    step();
    chk("rst_prio_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing a - b, LSB first, one bit per clock.
- Per-bit datapath is the full-subtractor counterpart of our 1-bit full-adder cell: difference = a ^ b ^ borrow_in; borrow_out = (~a & b) | (~(a ^ b) & borrow_in).
- A single borrow flip-flop carries the borrow between cycles, replacing a ripple chain.
- Sits beside the serial adder datapath for multi-cycle arithmetic, with a start/done handshake.

Parameters:
N, 8, operand and result width in bits (N >= 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request a subtraction; sampled only in IDLE
a  input  N  minuend, unsigned or two's complement; sampled on the accepted start edge
b  input  N  subtrahend, same format; sampled on the accepted start edge
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when the result is valid
sbit  output  1  serial difference bit produced this cycle; valid while in RUN
diff  output  N  parallel result a - b mod 2^N
borrow  output  1  final borrow out; 1 iff a < b unsigned
ovf  output  1  signed overflow of a - b

Behaviour:
- State machine: IDLE, RUN, DONE.
- Reset (rst=1 at a rising edge), from any state:
  - state goes to IDLE.
  - busy, done, sbit, diff, borrow, ovf all go to 0.
  - Internal shift registers, borrow flip-flop and bit counter are cleared.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- IDLE:
  - If start=1 at an edge: load shift registers sa<=a, sb<=b; borrow flip-flop bf<=0; counter cnt<=0; go to RUN.
  - Also capture the MSBs a[N-1] and b[N-1] for the overflow calculation.
  - diff, borrow and ovf keep their previous values until the new result is written.
- RUN, evaluated each cycle on the current values:
  - d = sa[0] ^ sb[0] ^ bf; sbit = d (combinational from the registers).
  - At the edge: bf <= (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf).
  - sa and sb shift right by 1.
  - The result shift register shifts right with d inserted at bit N-1.
  - cnt <= cnt + 1.
  - When cnt == N-1 at an edge (the last bit), go to DONE.
  - At that same edge, write diff from the final result shift value, borrow from the final bf, and ovf = (a_msb ^ b_msb) & (a_msb ^ d_msb).
  - cnt width is clog2(N); it never wraps within an operation.
- DONE: done=1 for exactly this one cycle; unconditionally return to IDLE at the next edge.
- Latency: start accepted at edge k gives RUN at edges k+1..k+N, done high in the cycle after edge k+N, and IDLE again after edge k+N+1.
  - Minimum start-to-start spacing is N+2 cycles.
- start is ignored in RUN and DONE; no queuing. a and b are don't-care outside the accept edge.
- diff, borrow and ovf stay stable from the DONE cycle until the next operation's final RUN edge or a reset.
- sbit is 0 outside RUN.
- rst has priority over start when both are high at the same edge.

Test Plan:
- N=8, a=100, b=37, start one cycle:
  - sbit sequence LSB first is 1,1,1,1,1,1,0,0.
  - done high in cycle 9 after the accept edge.
  - diff=63, borrow=0, ovf=0.
- a=5, b=9 -> diff=8'hFC (252), borrow=1, ovf=0.
- a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, ovf=1.
- a=8'h7F, b=8'hFF -> diff=8'h80, borrow=1, ovf=1.
- a=0, b=0 -> diff=0, borrow=0, ovf=0, all sbit=0.
- Handshake, start held high continuously with a=3, b=1:
  - done pulses every 10 cycles, width 1; diff=2.
  - Toggling a and b during RUN does not change the result.
- Reset mid-operation: assert rst at RUN bit 4 of a=200, b=50.
  - Next cycle: busy=0, diff=0, no done pulse.
  - A following start with a=200, b=50 yields diff=150, borrow=0.
